// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver handshake and register bus bundle for uart_rx_ctrl
//
// Purpose: groups the UART receiver byte handshake, the register access bus
//          and the interrupt line so they travel as one port.
// Signals:
//   rx_data[7:0]     receiver -> ctrl   byte held by the UART receiver
//   rx_data_ready    receiver -> ctrl   byte valid, held until acknowledged
//   rx_data_ack      ctrl -> receiver   one-cycle acknowledge
//   bus_sel          host -> ctrl       access strobe, one cycle per access
//   bus_we           host -> ctrl       1 = write, 0 = read
//   bus_addr[1:0]    host -> ctrl       0 DATA, 1 STATUS, 2 CTRL, 3 THRESH
//   bus_wdata[31:0]  host -> ctrl       write data
//   bus_rdata[31:0]  ctrl -> host       registered read data
//   bus_rvalid       ctrl -> host       read data valid, cycle after a read strobe
//   irq              ctrl -> host       level interrupt request
// Modports: slave = controller side, master = receiver/host side.

interface uart_rx_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_data_ack;
  logic        bus_sel;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq;

  modport slave (
    input  rx_data, rx_data_ready, bus_sel, bus_we, bus_addr, bus_wdata,
    output rx_data_ack, bus_rdata, bus_rvalid, irq
  );

  modport master (
    output rx_data, rx_data_ready, bus_sel, bus_we, bus_addr, bus_wdata,
    input  rx_data_ack, bus_rdata, bus_rvalid, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller with byte FIFO, registers and interrupt
//
// Purpose: captures bytes from a UART receiver through a ready/ack handshake,
//          queues them in a circular FIFO and exposes DATA/STATUS/CTRL/THRESH
//          registers plus a level interrupt.
// Ports:
//   clk    rising-edge clock for all logic
//   reset  synchronous, active-high reset
//   bus    uart_rx_ctrl_if.slave: receiver handshake, register bus, irq
// Parameter:
//   DEPTH  FIFO depth in bytes, power of two, 2..256

module uart_rx_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_ack;
  logic          w_sample;

  logic [7:0]    r_byte;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_enable;
  logic          r_irq_en;
  logic [7:0]    r_thresh;
  logic          r_ovr;
  logic [7:0]    r_ovr_cnt;

  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_irq;

  logic          w_rd;
  logic          w_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_flush;
  logic          w_space;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovr_evt;
  logic          w_ovr_clr;
  logic [8:0]    w_count9;
  logic [7:0]    w_thresh_eff;
  logic [31:0]   w_rd_mux;
  logic          w_unused;

  // Capture FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_data_ready) begin
          w_sample    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.rx_data_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_byte <= bus.rx_data;
    end
  end

  // Bus decode
  assign w_rd      = bus.bus_sel & ~bus.bus_we;
  assign w_wr      = bus.bus_sel & bus.bus_we;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = w_rd & (bus.bus_addr == ADDR_DATA) & ~w_empty;
  assign w_flush   = w_wr & (bus.bus_addr == ADDR_CTRL) & bus.bus_wdata[2];
  assign w_ovr_clr = w_wr & (bus.bus_addr == ADDR_STATUS) & bus.bus_wdata[2];

  // A full FIFO still has room when the head byte leaves in the same cycle.
  assign w_space    = ~w_full | w_pop;
  assign w_push_req = (r_state == ST_ACK) & r_enable;
  assign w_push     = w_push_req & w_space & ~w_flush;
  // A flushed byte is simply discarded, it is not an overrun.
  assign w_ovr_evt  = w_push_req & ~w_space & ~w_flush;

  // FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= r_byte;
    end
  end

  // Overrun tracking; a same-cycle clear wins over a new overrun.
  always_ff @(posedge clk) begin
    if (reset || w_ovr_clr) begin
      r_ovr     <= 1'b0;
      r_ovr_cnt <= 8'd0;
    end else if (w_ovr_evt) begin
      r_ovr <= 1'b1;
      if (r_ovr_cnt != 8'hFF) begin
        r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
    end
  end

  // CTRL and THRESH registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= 1'b1;
      r_irq_en <= 1'b0;
      r_thresh <= 8'd1;
    end else if (w_wr) begin
      if (bus.bus_addr == ADDR_CTRL) begin
        r_enable <= bus.bus_wdata[0];
        r_irq_en <= bus.bus_wdata[1];
      end
      if (bus.bus_addr == ADDR_THRESH) begin
        r_thresh <= bus.bus_wdata[7:0];
      end
    end
  end

  // Count widened to 9 bits so DEPTH=256 compares correctly against the threshold.
  assign w_count9     = 9'(r_count);
  assign w_thresh_eff = (r_thresh == 8'd0) ? 8'd1 : r_thresh;

  // Read mux sees pre-update state of this cycle.
  always_comb begin
    w_rd_mux = 32'h0;
    case (bus.bus_addr)
      ADDR_DATA:   w_rd_mux = w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr]};
      ADDR_STATUS: w_rd_mux = {8'h0, r_ovr_cnt, w_count9[7:0], 5'h0, r_ovr, w_full, w_empty};
      ADDR_CTRL:   w_rd_mux = {30'h0, r_irq_en, r_enable};
      ADDR_THRESH: w_rd_mux = {24'h0, r_thresh};
      default:     w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
      r_irq <= r_irq_en & ((w_count9 >= {1'b0, w_thresh_eff}) | r_ovr);
    end
  end

  assign bus.rx_data_ack = w_ack;
  assign bus.bus_rdata   = r_rdata;
  assign bus.bus_rvalid  = r_rvalid;
  assign bus.irq         = r_irq;

  assign w_unused = &{1'b0, bus.bus_wdata[31:8], w_count9[8]};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed and randomized self-checking bench for uart_rx_ctrl

module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mq[$];
  int          m_ovr_cnt;
  logic        m_ovr;
  logic        m_en;
  logic        m_irq_en;
  logic [7:0]  m_thresh;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr_cnt  = 0;
    m_ovr      = 1'b0;
    m_en       = 1'b1;
    m_irq_en   = 1'b0;
    m_thresh   = 8'd1;
    last_rdata = 32'h0;
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = mq.size();
    return {8'h0, 8'(m_ovr_cnt), 8'(n), 5'h0, m_ovr, (n == DEPTH), (n == 0)};
  endfunction

  function automatic logic model_irq();
    int thr;
    thr = (m_thresh == 8'd0) ? 1 : int'(m_thresh);
    return m_irq_en && ((mq.size() >= thr) || m_ovr);
  endfunction

  // Expected read value from the model; DATA reads consume the head byte.
  function automatic logic [31:0] model_read(input logic [1:0] addr);
    logic [31:0] v;
    v = 32'h0;
    case (addr)
      2'd0: if (mq.size() > 0) v = {24'h0, mq.pop_front()};
      2'd1: v = model_status();
      2'd2: v = {30'h0, m_irq_en, m_en};
      2'd3: v = {24'h0, m_thresh};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [1:0] addr, input logic [31:0] d);
    case (addr)
      2'd1: if (d[2]) begin m_ovr = 1'b0; m_ovr_cnt = 0; end
      2'd2: begin
        m_en     = d[0];
        m_irq_en = d[1];
        if (d[2]) mq.delete();
      end
      2'd3: m_thresh = d[7:0];
      default: ;
    endcase
  endtask

  task automatic rd(input logic [1:0] addr, input string tag, output logic [31:0] got);
    logic [31:0] exp;
    exp = model_read(addr);
    @(negedge clk);
    bus.bus_sel  = 1'b1;
    bus.bus_we   = 1'b0;
    bus.bus_addr = addr;
    @(negedge clk);
    bus.bus_sel = 1'b0;
    got = bus.bus_rdata;
    check({tag, "_rvalid"}, 32'(bus.bus_rvalid), 32'd1);
    check({tag, "_rdata"}, got, exp);
    last_rdata = exp;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] d, input string tag);
    @(negedge clk);
    bus.bus_sel   = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = addr;
    bus.bus_wdata = d;
    @(negedge clk);
    bus.bus_sel = 1'b0;
    bus.bus_we  = 1'b0;
    check({tag, "_rvalid0"}, 32'(bus.bus_rvalid), 32'd0);
    check({tag, "_rdata_hold"}, bus.bus_rdata, last_rdata);
    model_write(addr, d);
  endtask

  // op: 0 plain, 1 DATA read in the push cycle, 2 flush write in the push cycle
  task automatic send_byte(input logic [7:0] b, input int op, input string tag);
    int          lat;
    logic [31:0] exp_rd;
    exp_rd = 32'h0;
    @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rx_data_ack && lat < 8);
    check({tag, "_ack_latency"}, 32'(lat), 32'd1);
    bus.rx_data_ready = 1'b0;
    if (op == 1) begin
      bus.bus_sel  = 1'b1;
      bus.bus_we   = 1'b0;
      bus.bus_addr = 2'd0;
    end else if (op == 2) begin
      bus.bus_sel   = 1'b1;
      bus.bus_we    = 1'b1;
      bus.bus_addr  = 2'd2;
      bus.bus_wdata = {29'h0, 1'b1, m_irq_en, m_en};
    end
    if (op == 2) begin
      mq.delete();
    end else begin
      if (op == 1) exp_rd = model_read(2'd0);
      if (m_en) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(b);
        end else begin
          if (m_ovr_cnt < 255) m_ovr_cnt++;
          m_ovr = 1'b1;
        end
      end
    end
    @(negedge clk);
    bus.bus_sel = 1'b0;
    bus.bus_we  = 1'b0;
    check({tag, "_ack_one_cycle"}, 32'(bus.rx_data_ack), 32'd0);
    if (op == 1) begin
      check({tag, "_push_rd"}, bus.bus_rdata, exp_rd);
      last_rdata = exp_rd;
    end
    @(negedge clk);
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    check(tag, 32'(bus.irq), 32'(model_irq()));
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (mq.size() > 0) rd(2'd0, tag, d);
  endtask

  logic [31:0] rv;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.rx_data       = 8'h00;
    bus.rx_data_ready = 1'b0;
    bus.bus_sel       = 1'b0;
    bus.bus_we        = 1'b0;
    bus.bus_addr      = 2'd0;
    bus.bus_wdata     = 32'h0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.rx_data_ack), 32'd0);
    check("rst_rvalid", 32'(bus.bus_rvalid), 32'd0);
    check("rst_rdata", bus.bus_rdata, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    reset = 1'b0;

    rd(2'd1, "rst_status", rv);
    check("rst_status_const", rv, 32'h0000_0001);
    rd(2'd2, "rst_ctrl", rv);
    check("rst_ctrl_const", rv, 32'h0000_0001);
    rd(2'd3, "rst_thresh", rv);
    check("rst_thresh_const", rv, 32'h0000_0001);

    // Single byte
    send_byte(8'hA5, 0, "single");
    rd(2'd1, "single_status", rv);
    check("single_count1", rv, 32'h0000_0100);
    rd(2'd0, "single_data", rv);
    check("single_a5", rv, 32'h0000_00A5);
    rd(2'd1, "single_status2", rv);

    // Empty read leaves pointers alone
    rd(2'd0, "empty_data", rv);
    check("empty_zero", rv, 32'h0);
    send_byte(8'h3C, 0, "after_empty");
    rd(2'd0, "after_empty_data", rv);
    check("after_empty_3c", rv, 32'h0000_003C);

    // Overrun
    for (int i = 0; i < DEPTH + 3; i++) send_byte(8'($urandom), 0, "ovr_fill");
    rd(2'd1, "ovr_status", rv);
    check("ovr_status_const", rv, 32'h0003_0806);
    wr(2'd1, 32'h4, "ovr_clear");
    rd(2'd1, "ovr_status_clr", rv);
    check("ovr_clr_const", rv, 32'h0000_0802);
    drain("ovr_drain");

    // Full FIFO, read in the push cycle
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 0, "full_fill");
    send_byte(8'h77, 1, "full_rdpush");
    rd(2'd1, "full_rdpush_status", rv);
    check("full_rdpush_const", rv, 32'h0000_0802);
    drain("full_drain");

    // Threshold interrupt
    wr(2'd2, 32'h3, "irq_ctrl");
    wr(2'd3, 32'h3, "irq_thresh");
    send_byte(8'h11, 0, "irq_b1");
    send_byte(8'h22, 0, "irq_b2");
    check_irq("irq_two");
    check("irq_two_const", 32'(bus.irq), 32'd0);
    send_byte(8'h33, 0, "irq_b3");
    check_irq("irq_three");
    check("irq_three_const", 32'(bus.irq), 32'd1);
    rd(2'd0, "irq_pop", rv);
    check_irq("irq_after_pop");
    check("irq_after_pop_const", 32'(bus.irq), 32'd0);
    drain("irq_drain");

    // Flush in the push cycle
    send_byte(8'h44, 0, "flush_pre");
    send_byte(8'h55, 2, "flush_push");
    rd(2'd1, "flush_status", rv);
    check("flush_empty_const", rv, 32'h0000_0001);

    // Enable off: acked, dropped, no overrun
    wr(2'd2, 32'h0, "dis_ctrl");
    send_byte(8'h66, 0, "dis_byte");
    rd(2'd1, "dis_status", rv);
    wr(2'd2, 32'h1, "en_ctrl");

    // Reset during ACK
    send_byte(8'h12, 0, "rst_mid_pre");
    @(negedge clk);
    bus.rx_data       = 8'h99;
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ack", 32'(bus.rx_data_ack), 32'd1);
    reset = 1'b1;
    bus.rx_data_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_mid_ack0", 32'(bus.rx_data_ack), 32'd0);
    rd(2'd1, "rst_mid_status", rv);
    send_byte(8'hC3, 0, "rst_mid_post");
    rd(2'd0, "rst_mid_data", rv);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      int sub;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        sub = $urandom_range(0, 9);
        send_byte(8'($urandom), (sub < 7) ? 0 : ((sub < 9) ? 1 : 2), "rnd_send");
      end else if (r < 70) begin
        rd(2'd0, "rnd_data", rv);
      end else if (r < 80) begin
        rd(2'd1, "rnd_status", rv);
      end else if (r < 85) begin
        wr(2'd2, {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) != 0)}, "rnd_ctrl");
      end else if (r < 90) begin
        wr(2'd3, 32'($urandom_range(0, 9)), "rnd_thresh");
      end else if (r < 93) begin
        wr(2'd1, 32'($urandom) | 32'h4, "rnd_clr");
      end else if (r < 96) begin
        wr(2'd0, $urandom, "rnd_data_wr");
      end else begin
        rd(2'($urandom_range(2, 3)), "rnd_cfg", rv);
      end
      check_irq("rnd_irq");
    end
    rd(2'd1, "final_status", rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
